rv_alu_thread_arb: RTL and testbench

Round-robin issue arbiter and two-stage pipeline that shares the single `rv_alu_v` instance between `NTHREADS` hardware threads. Each thread presents one ALU operation (opcode, funct3, funct7, Op1, Op2) through a valid/ready handshake. The block registers the granted operation onto the ALU inputs, captures `Rez` one cycle later, and returns it with its thread tag over a back-pressured response channel. At most one operation per thread is in flight, which keeps per-thread results in order.

---
 rtl/rv_alu_thread_arb.sv | 162 ++++++++++++++++
 tb/tb_rv_alu_thread_arb.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_alu_thread_arb.sv
// rv_alu_thread_arb
//
// Shares one rv_alu_v instance between NTHREADS hardware threads. A round-robin
// arbiter picks one requesting thread per cycle. Its operation is registered onto
// the ALU inputs (stage 1). The ALU result is captured one cycle later into a
// back-pressured response register (stage 2). Each thread can have at most one
// operation in flight, so every thread gets its results back in order.
//
// Ports
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   req_valid[NTHREADS]      per-thread request
//   req_ready[NTHREADS]      one-hot grant (combinational)
//   req_opcode/funct3/funct7 packed per-thread op fields (7/3/7 bits each)
//   req_op1/req_op2          packed per-thread 32-bit operands
//   alu_opcode..alu_op2      registered stage-1 fields driving the ALU
//   alu_rez                  combinational ALU result
//   rsp_valid/rsp_ready      response handshake
//   rsp_tid/rsp_data         thread id and captured result of the response
//   busy[NTHREADS]           thread has an operation in flight

module rv_alu_thread_arb #(
    parameter int NTHREADS = 4,
    parameter int TIDW     = $clog2(NTHREADS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NTHREADS-1:0]    req_valid,
    output logic [NTHREADS-1:0]    req_ready,
    input  logic [7*NTHREADS-1:0]  req_opcode,
    input  logic [3*NTHREADS-1:0]  req_funct3,
    input  logic [7*NTHREADS-1:0]  req_funct7,
    input  logic [32*NTHREADS-1:0] req_op1,
    input  logic [32*NTHREADS-1:0] req_op2,
    output logic [6:0]             alu_opcode,
    output logic [2:0]             alu_funct3,
    output logic [6:0]             alu_funct7,
    output logic [31:0]            alu_op1,
    output logic [31:0]            alu_op2,
    input  logic [31:0]            alu_rez,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [TIDW-1:0]        rsp_tid,
    output logic [31:0]            rsp_data,
    output logic [NTHREADS-1:0]    busy
);

    logic                s1_valid;
    logic [TIDW-1:0]     s1_tid;
    logic [TIDW-1:0]     last;

    logic                s2_load;
    logic                s1_free;
    logic [NTHREADS-1:0] rsp_fire;
    logic [NTHREADS-1:0] elig;
    logic [NTHREADS-1:0] grant;
    logic [TIDW-1:0]     grant_tid;
    logic                accept;
    logic [TIDW-1:0]     idx;

    logic [6:0]          sel_opcode;
    logic [2:0]          sel_funct3;
    logic [6:0]          sel_funct7;
    logic [31:0]         sel_op1;
    logic [31:0]         sel_op2;

    // S2 takes S1 whenever the response slot is empty or being drained this
    // cycle; S1 can then accept a new op in the same cycle.
    assign s2_load = s1_valid & (~rsp_valid | rsp_ready);
    assign s1_free = ~s1_valid | s2_load;

    // A thread retiring this cycle may re-issue immediately, so its busy bit
    // does not block eligibility while its response fires.
    always_comb begin
        rsp_fire = '0;
        for (int i = 0; i < NTHREADS; i++) begin
            rsp_fire[i] = rsp_valid & rsp_ready & (rsp_tid == TIDW'(i));
        end
    end

    assign elig = req_valid & (~busy | rsp_fire);

    // Round-robin search starting just after the last granted thread. The
    // modulo keeps the search correct when NTHREADS is not a power of two.
    always_comb begin
        grant     = '0;
        grant_tid = '0;
        accept    = 1'b0;
        idx       = '0;
        if (s1_free) begin
            for (int k = 1; k <= NTHREADS; k++) begin
                idx = TIDW'((int'(last) + k) % NTHREADS);
                if (!accept && elig[idx]) begin
                    accept     = 1'b1;
                    grant[idx] = 1'b1;
                    grant_tid  = idx;
                end
            end
        end
    end

    assign req_ready = grant;

    // Field mux for the granted thread.
    always_comb begin
        sel_opcode = req_opcode[7*int'(grant_tid) +: 7];
        sel_funct3 = req_funct3[3*int'(grant_tid) +: 3];
        sel_funct7 = req_funct7[7*int'(grant_tid) +: 7];
        sel_op1    = req_op1[32*int'(grant_tid) +: 32];
        sel_op2    = req_op2[32*int'(grant_tid) +: 32];
    end

    // Stage 1: the alu_* registers only load on accept, so they keep their
    // last values while S1 is empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_tid     <= '0;
            last       <= TIDW'(NTHREADS - 1);
            alu_opcode <= '0;
            alu_funct3 <= '0;
            alu_funct7 <= '0;
            alu_op1    <= '0;
            alu_op2    <= '0;
        end else if (accept) begin
            s1_valid   <= 1'b1;
            s1_tid     <= grant_tid;
            last       <= grant_tid;
            alu_opcode <= sel_opcode;
            alu_funct3 <= sel_funct3;
            alu_funct7 <= sel_funct7;
            alu_op1    <= sel_op1;
            alu_op2    <= sel_op2;
        end else if (s2_load) begin
            s1_valid   <= 1'b0;
        end
    end

    // Stage 2: response register; fields are stable while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_tid   <= '0;
            rsp_data  <= '0;
        end else if (s2_load) begin
            rsp_valid <= 1'b1;
            rsp_tid   <= s1_tid;
            rsp_data  <= alu_rez;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

    // Set wins over clear so a same-cycle retire and re-issue stays busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= (busy & ~rsp_fire) | grant;
        end
    end

endmodule

// File: tb/tb_rv_alu_thread_arb.sv
// Directed testbench for rv_alu_thread_arb with NTHREADS=4. Inputs change just
// after a rising edge and everything is checked 2 ns later, inside the same cycle.
// A small behavioural ALU closes the loop from alu_* back to alu_rez.

module tb_rv_alu_thread_arb;

    localparam int NT = 4;
    localparam int TW = 2;

    logic            clk;
    logic            rst;
    logic [NT-1:0]   req_valid;
    logic [NT-1:0]   req_ready;
    logic [7*NT-1:0] req_opcode;
    logic [3*NT-1:0] req_funct3;
    logic [7*NT-1:0] req_funct7;
    logic [32*NT-1:0] req_op1;
    logic [32*NT-1:0] req_op2;
    logic [6:0]      alu_opcode;
    logic [2:0]      alu_funct3;
    logic [6:0]      alu_funct7;
    logic [31:0]     alu_op1;
    logic [31:0]     alu_op2;
    logic [31:0]     alu_rez;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [TW-1:0]   rsp_tid;
    logic [31:0]     rsp_data;
    logic [NT-1:0]   busy;

    int checksPassed;
    int checksTotal;

    rv_alu_thread_arb #(.NTHREADS(NT), .TIDW(TW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_opcode (req_opcode),
        .req_funct3 (req_funct3),
        .req_funct7 (req_funct7),
        .req_op1    (req_op1),
        .req_op2    (req_op2),
        .alu_opcode (alu_opcode),
        .alu_funct3 (alu_funct3),
        .alu_funct7 (alu_funct7),
        .alu_op1    (alu_op1),
        .alu_op2    (alu_op2),
        .alu_rez    (alu_rez),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_tid    (rsp_tid),
        .rsp_data   (rsp_data),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Minimal ALU stand-in: ADD/SUB on funct3=000, XOR on funct3=100.
    always_comb begin
        alu_rez = 32'h0;
        case (alu_funct3)
            3'b000: alu_rez = alu_funct7[5] ? (alu_op1 - alu_op2) : (alu_op1 + alu_op2);
            3'b100: alu_rez = alu_op1 ^ alu_op2;
            default: alu_rez = 32'h0;
        endcase
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checksTotal++;
        if (observed === expected) begin
            checksPassed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic applyStimulus(input logic [NT-1:0] valid, input logic ready);
        req_valid = valid;
        rsp_ready = ready;
    endtask

    task automatic setOp(input int tid, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] a, input logic [31:0] b);
        req_opcode[7*tid +: 7]  = 7'b0110011;
        req_funct3[3*tid +: 3]  = f3;
        req_funct7[7*tid +: 7]  = f7;
        req_op1[32*tid +: 32]   = a;
        req_op2[32*tid +: 32]   = b;
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus(4'b0000, 1'b1);
        nextCycle();
        nextCycle();
        rst = 1'b0;
    endtask

    initial begin
        checksPassed = 0;
        checksTotal  = 0;
        rst        = 1'b1;
        req_valid  = '0;
        rsp_ready  = 1'b1;
        req_opcode = '0;
        req_funct3 = '0;
        req_funct7 = '0;
        req_op1    = '0;
        req_op2    = '0;

        // Reset state
        doReset();
        settle();
        checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_alu_op1", alu_op1, 32'd0);
        checkOutput("reset_rsp_data", rsp_data, 32'd0);
        checkOutput("reset_req_ready", 32'(req_ready), 32'd0);

        // Single op on thread 2: 5 + 7
        setOp(2, 3'b000, 7'h00, 32'd5, 32'd7);
        applyStimulus(4'b0100, 1'b1);
        settle();
        checkOutput("single_grant", 32'(req_ready), 32'h4);
        nextCycle();
        applyStimulus(4'b0000, 1'b1);
        settle();
        checkOutput("single_alu_op1", alu_op1, 32'd5);
        checkOutput("single_alu_op2", alu_op2, 32'd7);
        checkOutput("single_alu_opcode", 32'(alu_opcode), 32'h33);
        checkOutput("single_busy", 32'(busy), 32'h4);
        checkOutput("single_rsp_early", 32'(rsp_valid), 32'd0);
        nextCycle();
        settle();
        checkOutput("single_rsp_valid", 32'(rsp_valid), 32'd1);
        checkOutput("single_rsp_tid", 32'(rsp_tid), 32'd2);
        checkOutput("single_rsp_data", rsp_data, 32'd12);
        nextCycle();
        settle();
        checkOutput("single_retired", 32'(rsp_valid), 32'd0);
        checkOutput("single_busy_clr", 32'(busy), 32'd0);

        // Round robin: thread i computes (100+i)+i
        doReset();
        for (int i = 0; i < NT; i++) setOp(i, 3'b000, 7'h00, 32'(100 + i), 32'(i));
        for (int k = 0; k < 8; k++) begin
            applyStimulus(4'b1111, 1'b1);
            settle();
            checkOutput($sformatf("rr_grant_%0d", k), 32'(req_ready), 32'(1 << (k % 4)));
            if (k >= 2) begin
                checkOutput($sformatf("rr_rsp_valid_%0d", k), 32'(rsp_valid), 32'd1);
                checkOutput($sformatf("rr_rsp_tid_%0d", k), 32'(rsp_tid), 32'((k - 2) % 4));
                checkOutput($sformatf("rr_rsp_data_%0d", k), rsp_data, 32'(100 + 2 * ((k - 2) % 4)));
            end
            nextCycle();
        end
        applyStimulus(4'b0000, 1'b1);
        settle();
        checkOutput("rr_drain_tid2", 32'(rsp_tid), 32'd2);
        nextCycle();
        settle();
        checkOutput("rr_drain_tid3", 32'(rsp_tid), 32'd3);
        checkOutput("rr_drain_data3", rsp_data, 32'd106);
        nextCycle();
        settle();
        checkOutput("rr_idle_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rr_idle_busy", 32'(busy), 32'd0);

        // Pointer wrap: last grant was thread 3, threads 1 and 3 request
        setOp(1, 3'b000, 7'h00, 32'd1, 32'd2);
        setOp(3, 3'b000, 7'h00, 32'd30, 32'd3);
        applyStimulus(4'b1010, 1'b1);
        settle();
        checkOutput("wrap_first", 32'(req_ready), 32'h2);
        nextCycle();
        applyStimulus(4'b1000, 1'b1);
        settle();
        checkOutput("wrap_second", 32'(req_ready), 32'h8);
        nextCycle();
        applyStimulus(4'b0000, 1'b1);
        settle();
        checkOutput("wrap_rsp1_tid", 32'(rsp_tid), 32'd1);
        checkOutput("wrap_rsp1_data", rsp_data, 32'd3);
        nextCycle();
        settle();
        checkOutput("wrap_rsp3_tid", 32'(rsp_tid), 32'd3);
        checkOutput("wrap_rsp3_data", rsp_data, 32'd33);

        // Back-pressure: t0 = 40+2, t1 = 50-5, t2 = 7^8
        doReset();
        setOp(0, 3'b000, 7'h00, 32'd40, 32'd2);
        setOp(1, 3'b000, 7'h20, 32'd50, 32'd5);
        setOp(2, 3'b100, 7'h00, 32'd7, 32'd8);
        setOp(3, 3'b000, 7'h00, 32'd9, 32'd9);
        applyStimulus(4'b0011, 1'b0);
        settle();
        checkOutput("bp_grant0", 32'(req_ready), 32'h1);
        nextCycle();
        applyStimulus(4'b0010, 1'b0);
        settle();
        checkOutput("bp_grant1", 32'(req_ready), 32'h2);
        nextCycle();
        applyStimulus(4'b1100, 1'b0);
        settle();
        checkOutput("bp_full_ready", 32'(req_ready), 32'h0);
        checkOutput("bp_rsp_tid_a", 32'(rsp_tid), 32'd0);
        checkOutput("bp_rsp_data_a", rsp_data, 32'd42);
        checkOutput("bp_s1_hold", alu_op1, 32'd50);
        nextCycle();
        settle();
        checkOutput("bp_still_ready", 32'(req_ready), 32'h0);
        checkOutput("bp_rsp_valid_b", 32'(rsp_valid), 32'd1);
        checkOutput("bp_rsp_data_b", rsp_data, 32'd42);
        checkOutput("bp_busy", 32'(busy), 32'h3);
        nextCycle();
        applyStimulus(4'b1100, 1'b1);
        settle();
        checkOutput("bp_release_tid", 32'(rsp_tid), 32'd0);
        checkOutput("bp_release_grant", 32'(req_ready), 32'h4);
        nextCycle();
        applyStimulus(4'b0000, 1'b1);
        settle();
        checkOutput("bp_rsp1_tid", 32'(rsp_tid), 32'd1);
        checkOutput("bp_rsp1_data", rsp_data, 32'd45);
        nextCycle();
        settle();
        checkOutput("bp_rsp2_tid", 32'(rsp_tid), 32'd2);
        checkOutput("bp_rsp2_data", rsp_data, 32'd15);

        // Same-thread re-issue on thread 3: 3 + 4
        doReset();
        setOp(3, 3'b000, 7'h00, 32'd3, 32'd4);
        applyStimulus(4'b1000, 1'b1);
        settle();
        checkOutput("reissue_t0", 32'(req_ready), 32'h8);
        nextCycle();
        settle();
        checkOutput("reissue_t1_ready", 32'(req_ready), 32'h0);
        checkOutput("reissue_t1_busy", 32'(busy), 32'h8);
        nextCycle();
        settle();
        checkOutput("reissue_t2_ready", 32'(req_ready), 32'h8);
        checkOutput("reissue_t2_rsp", rsp_data, 32'd7);
        nextCycle();
        settle();
        checkOutput("reissue_t3_ready", 32'(req_ready), 32'h0);
        checkOutput("reissue_t3_busy", 32'(busy), 32'h8);
        nextCycle();
        settle();
        checkOutput("reissue_t4_ready", 32'(req_ready), 32'h8);
        checkOutput("reissue_t4_busy", 32'(busy), 32'h8);
        nextCycle();
        applyStimulus(4'b0000, 1'b1);

        // Reset with both stages full
        doReset();
        applyStimulus(4'b0011, 1'b0);
        nextCycle();
        applyStimulus(4'b0010, 1'b0);
        nextCycle();
        applyStimulus(4'b0000, 1'b0);
        settle();
        checkOutput("midrst_full", 32'(rsp_valid), 32'd1);
        rst = 1'b1;
        nextCycle();
        rst = 1'b0;
        applyStimulus(4'b1111, 1'b1);
        settle();
        checkOutput("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_grant", 32'(req_ready), 32'h1);
        nextCycle();
        applyStimulus(4'b0000, 1'b1);
        nextCycle();
        nextCycle();

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
